// File: rtl/pipe_stall_ctrl.sv
// Pipeline advance/stall/flush controller: one common load enable, per-stage valids,
// per-port response capture, deferred flush, stall watchdog and saturating stall counter.
module pipe_stall_ctrl #(
  parameter int NUM_STAGES    = 5,
  parameter int NUM_MEM_PORTS = 2,
  parameter int FLUSH_DEPTH   = 4,
  parameter int MAX_WAIT      = 255,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_MEM_PORTS-1:0] mem_req,
  input  logic [NUM_MEM_PORTS-1:0] mem_resp,
  input  logic                     fetch_valid,
  input  logic                     flush,
  output logic                     stage_load,
  output logic [NUM_STAGES-1:0]    stage_valid,
  output logic                     stall,
  output logic                     timeout,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [NUM_MEM_PORTS-1:0] done_reg;
  logic [NUM_MEM_PORTS-1:0] sat;
  logic                     flush_pend_reg;
  logic                     flush_eff;
  logic [WAIT_W-1:0]        wait_cnt_reg;
  logic [WAIT_W-1:0]        wait_cnt_next;
  logic                     timeout_reg;
  logic [CNT_W-1:0]         stall_count_reg;
  logic [NUM_STAGES-1:0]    stage_valid_reg;
  logic [NUM_STAGES-1:0]    valid_next;
  logic [NUM_STAGES-1:0]    shift_in;
  logic [NUM_STAGES-1:0]    kill_mask;

  // A port is satisfied if idle, answering now, or already answered during this stall.
  assign sat        = ~mem_req | mem_resp | done_reg;
  assign stall      = rst_n & ~(&sat);
  assign stage_load = rst_n & (&sat);
  assign flush_eff  = flush | flush_pend_reg;

  assign shift_in[0] = fetch_valid;
  genvar gi;
  generate
    for (gi = 1; gi < NUM_STAGES; gi++) begin : g_shift
      assign shift_in[gi] = stage_valid_reg[gi-1];
    end
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_kill
      assign kill_mask[gi] = (gi < FLUSH_DEPTH);
    end
  endgenerate

  always_comb begin
    valid_next = stage_valid_reg;
    if (stage_load)
      valid_next = shift_in & ~({NUM_STAGES{flush_eff}} & kill_mask);
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (stage_load)
      wait_cnt_next = '0;
    else if (stall && wait_cnt_reg != WAIT_MAX)
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg        <= '0;
      flush_pend_reg  <= 1'b0;
      wait_cnt_reg    <= '0;
      timeout_reg     <= 1'b0;
      stall_count_reg <= '0;
      stage_valid_reg <= '0;
    end else begin
      stage_valid_reg <= valid_next;
      wait_cnt_reg    <= wait_cnt_next;
      if (wait_cnt_next == WAIT_MAX)
        timeout_reg <= 1'b1;
      // Captured responses are consumed by exactly one advance.
      if (stage_load) begin
        done_reg       <= '0;
        flush_pend_reg <= 1'b0;
      end else begin
        done_reg <= done_reg | (mem_req & mem_resp & {NUM_MEM_PORTS{stall}});
        if (flush && stall)
          flush_pend_reg <= 1'b1;
      end
      if (stall && stall_count_reg != {CNT_W{1'b1}})
        stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign stage_valid = stage_valid_reg;
  assign timeout     = timeout_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (flush depth 4 and 2) share stimulus;
// a vector table supplies inputs and expectations, a queue pairs them with DUT outputs.
module tb_pipe_stall_ctrl;

  typedef struct {
    logic [1:0] req;
    logic [1:0] resp;
    logic       fv;
    logic       fl;
    logic       exp_stall;
    logic       exp_load;
    logic [4:0] exp_va;
    logic [4:0] exp_vb;
    logic       exp_to;
    logic [3:0] exp_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mem_req;
  logic [1:0] mem_resp;
  logic       fetch_valid;
  logic       flush;

  logic       load_a, stall_a, to_a;
  logic [4:0] valid_a;
  logic [3:0] cnt_a;
  logic       load_b, stall_b, to_b;
  logic [4:0] valid_b;
  logic [3:0] cnt_b;

  int vectors;
  int miscompares;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.NUM_STAGES(5), .NUM_MEM_PORTS(2), .FLUSH_DEPTH(4), .MAX_WAIT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_resp(mem_resp),
    .fetch_valid(fetch_valid), .flush(flush), .stage_load(load_a), .stage_valid(valid_a),
    .stall(stall_a), .timeout(to_a), .stall_count(cnt_a));

  pipe_stall_ctrl #(.NUM_STAGES(5), .NUM_MEM_PORTS(2), .FLUSH_DEPTH(2), .MAX_WAIT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_resp(mem_resp),
    .fetch_valid(fetch_valid), .flush(flush), .stage_load(load_b), .stage_valid(valid_b),
    .stall(stall_b), .timeout(to_b), .stall_count(cnt_b));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] req, input logic [1:0] resp, input logic fv, input logic fl,
                     input logic st, input logic ld, input logic [4:0] va, input logic [4:0] vb,
                     input logic to, input logic [3:0] cnt);
    vec_t v;
    v.req = req; v.resp = resp; v.fv = fv; v.fl = fl;
    v.exp_stall = st; v.exp_load = ld; v.exp_va = va; v.exp_vb = vb;
    v.exp_to = to; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    check({tag, "_stall"}, 16'(stall_a), 16'd0);
    check({tag, "_load"},  16'(load_a),  16'd0);
    check({tag, "_va"},    16'(valid_a), 16'd0);
    check({tag, "_vb"},    16'(valid_b), 16'd0);
    check({tag, "_to"},    16'(to_a),    16'd0);
    check({tag, "_cnt"},   16'(cnt_a),   16'd0);
    $display("vec %0d %s: stall=%b load=%b va=%b vb=%b to=%b cnt=%0d",
             vectors, tag, stall_a, load_a, valid_a, valid_b, to_a, cnt_a);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    //   req    resp  fv fl  st ld  va        vb        to cnt
    // idle fill
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b00000, 5'b00000, 0, 0);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b00001, 5'b00001, 0, 0);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b00011, 5'b00011, 0, 0);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b00111, 5'b00111, 0, 0);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b01111, 5'b01111, 0, 0);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b11111, 5'b11111, 0, 0);
    // split responses
    add(2'b11, 2'b01, 1, 0, 1, 0, 5'b11111, 5'b11111, 0, 0);
    add(2'b11, 2'b00, 1, 0, 1, 0, 5'b11111, 5'b11111, 0, 1);
    add(2'b11, 2'b00, 1, 0, 1, 0, 5'b11111, 5'b11111, 0, 2);
    add(2'b11, 2'b10, 1, 0, 0, 1, 5'b11111, 5'b11111, 0, 3);
    // captured response must not survive the advance
    add(2'b11, 2'b10, 1, 0, 1, 0, 5'b11111, 5'b11111, 0, 3);
    add(2'b11, 2'b01, 1, 0, 0, 1, 5'b11111, 5'b11111, 0, 4);
    // flush during stall
    add(2'b10, 2'b00, 1, 0, 1, 0, 5'b11111, 5'b11111, 0, 4);
    add(2'b10, 2'b00, 1, 1, 1, 0, 5'b11111, 5'b11111, 0, 5);
    add(2'b10, 2'b00, 1, 0, 1, 0, 5'b11111, 5'b11111, 0, 6);
    add(2'b10, 2'b10, 1, 0, 0, 1, 5'b11111, 5'b11111, 0, 7);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b10000, 5'b11100, 0, 7);
    // flush on advance
    add(2'b00, 2'b00, 1, 1, 0, 1, 5'b00001, 5'b11001, 0, 7);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b00000, 5'b10000, 0, 7);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b00001, 5'b00001, 0, 7);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b00011, 5'b00011, 0, 7);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b00111, 5'b00111, 0, 7);
    add(2'b00, 2'b00, 1, 0, 0, 1, 5'b01111, 5'b01111, 0, 7);
    add(2'b00, 2'b00, 1, 1, 0, 1, 5'b11111, 5'b11111, 0, 7);
    add(2'b00, 2'b00, 0, 0, 0, 1, 5'b10000, 5'b11100, 0, 7);
    add(2'b00, 2'b00, 0, 0, 0, 1, 5'b00000, 5'b11000, 0, 7);
    // watchdog
    add(2'b10, 2'b00, 1, 0, 1, 0, 5'b00000, 5'b10000, 0, 7);
    add(2'b10, 2'b00, 1, 0, 1, 0, 5'b00000, 5'b10000, 0, 8);
    add(2'b10, 2'b00, 1, 0, 1, 0, 5'b00000, 5'b10000, 0, 9);
    add(2'b10, 2'b00, 1, 0, 1, 0, 5'b00000, 5'b10000, 0, 10);
    add(2'b10, 2'b00, 1, 0, 1, 0, 5'b00000, 5'b10000, 1, 11);
    add(2'b10, 2'b10, 1, 0, 0, 1, 5'b00000, 5'b10000, 1, 12);
    add(2'b00, 2'b00, 0, 0, 0, 1, 5'b00001, 5'b00001, 1, 12);
    // counter saturation
    add(2'b01, 2'b00, 0, 0, 1, 0, 5'b00010, 5'b00010, 1, 12);
    add(2'b01, 2'b00, 0, 0, 1, 0, 5'b00010, 5'b00010, 1, 13);
    add(2'b01, 2'b00, 0, 0, 1, 0, 5'b00010, 5'b00010, 1, 14);
    add(2'b01, 2'b00, 0, 0, 1, 0, 5'b00010, 5'b00010, 1, 15);
    add(2'b01, 2'b00, 0, 0, 1, 0, 5'b00010, 5'b00010, 1, 15);
    add(2'b01, 2'b00, 0, 0, 1, 0, 5'b00010, 5'b00010, 1, 15);
    // simultaneous responses, then request dropped mid-wait
    add(2'b11, 2'b11, 0, 0, 0, 1, 5'b00010, 5'b00010, 1, 15);
    add(2'b01, 2'b00, 0, 0, 1, 0, 5'b00100, 5'b00100, 1, 15);
    add(2'b00, 2'b00, 0, 0, 0, 1, 5'b00100, 5'b00100, 1, 15);
    // stall with a pending flush, ahead of the async reset
    add(2'b10, 2'b00, 0, 1, 1, 0, 5'b01000, 5'b01000, 1, 15);

    rst_n = 1'b0;
    mem_req = 2'b11;
    mem_resp = 2'b00;
    fetch_valid = 1'b1;
    flush = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      mem_req = vecs[i].req;
      mem_resp = vecs[i].resp;
      fetch_valid = vecs[i].fv;
      flush = vecs[i].fl;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      check("stall", 16'(stall_a), 16'(e.exp_stall));
      check("load",  16'(load_a),  16'(e.exp_load));
      check("valid_a", 16'(valid_a), 16'(e.exp_va));
      check("valid_b", 16'(valid_b), 16'(e.exp_vb));
      check("timeout", 16'(to_a),  16'(e.exp_to));
      check("stall_count", 16'(cnt_a), 16'(e.exp_cnt));
      $display("vec %0d: req=%b resp=%b fv=%b fl=%b -> stall=%b load=%b va=%b vb=%b to=%b cnt=%0d",
               vectors, e.req, e.resp, e.fv, e.fl, stall_a, load_a, valid_a, valid_b, to_a, cnt_a);
      @(posedge clk);
      #1;
    end

    // Still stalled with flush pending and timeout set; reset must clear everything without an edge.
    flush = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_req = 2'b00;
    fetch_valid = 1'b1;
    @(negedge clk);
    vectors++;
    check("post_reset_load", 16'(load_a), 16'd1);
    check("post_reset_valid", 16'(valid_a), 16'd0);
    $display("vec %0d post_reset: load=%b va=%b", vectors, load_a, valid_a);
    @(posedge clk);
    #1;
    vectors++;
    check("pend_discarded_a", 16'(valid_a), 16'b00001);
    check("pend_discarded_b", 16'(valid_b), 16'b00001);
    $display("vec %0d pend_discarded: va=%b vb=%b", vectors, valid_a, valid_b);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
